// File: rtl/scroll_banner.sv
// Scrolling 7-segment banner: UART command bytes edit a circular character
// buffer, and a D-wide window over it scrolls left/right at one of four speeds.
module scroll_banner #(
  parameter int TICK_CYCLES = 25_000_000,
  parameter int W           = 10,
  parameter int D           = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  output logic [5*D-1:0]       disp,
  output logic [$clog2(D)-1:0] cursor,
  output logic                 play,
  output logic                 edit,
  output logic                 dir,
  output logic                 cmd_err
);

  localparam int TW = $clog2(TICK_CYCLES);
  localparam int HW = (W > 1) ? $clog2(W) : 1;
  localparam int CW = $clog2(D);
  localparam logic [4:0] BLANK = 5'h10;

  typedef enum logic [3:0] {
    CMD_NONE,
    CMD_GO,
    CMD_PAUSE,
    CMD_MARK,
    CMD_REV,
    CMD_FASTER,
    CMD_SLOWER,
    CMD_CLEAR,
    CMD_CHAR,
    CMD_BAD
  } cmd_t;

  // Registered state
  logic [4:0]    ent [W];
  logic [HW-1:0] head;
  logic [TW-1:0] tcnt;
  logic [1:0]    speed;
  logic [1:0]    sc;
  logic          blink;
  logic          play_q;
  logic          edit_q;
  logic          dir_q;
  logic [CW-1:0] cur_q;
  logic          err_q;

  // Next-state values
  logic [4:0]    ent_n [W];
  logic [HW-1:0] head_n;
  logic [TW-1:0] tcnt_n;
  logic [1:0]    speed_n;
  logic [1:0]    sc_n;
  logic          blink_n;
  logic          play_n;
  logic          edit_n;
  logic          dir_n;
  logic [CW-1:0] cur_n;
  logic          err_n;

  cmd_t       cmd;
  logic [4:0] char_val;
  logic       tick;
  logic       scroll;
  logic [CW-1:0] cur_inc;

  function automatic logic [HW-1:0] wrap_add(input logic [HW-1:0] a, input int b);
    int s;
    s = int'(a) + b;
    if (s >= W) s = s - W;
    return HW'(s);
  endfunction

  // rx_valid is a one-cycle strobe with no back-pressure: every strobed byte
  // is consumed on the edge where it is presented, back-to-back included.
  always_comb begin
    cmd      = CMD_NONE;
    char_val = BLANK;
    if (rx_valid) begin
      case (rx_data)
        8'h47, 8'h67: cmd = CMD_GO;
        8'h50, 8'h70: cmd = CMD_PAUSE;
        8'h4D, 8'h6D: cmd = CMD_MARK;
        8'h52, 8'h72: cmd = CMD_REV;
        8'h2B:        cmd = CMD_FASTER;
        8'h2D:        cmd = CMD_SLOWER;
        8'h43, 8'h63: cmd = CMD_CLEAR;
        8'h20, 8'h5F: cmd = edit_q ? CMD_CHAR : CMD_BAD;
        default: begin
          if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
            cmd      = edit_q ? CMD_CHAR : CMD_BAD;
            char_val = {1'b0, rx_data[3:0]};
          end else begin
            cmd = CMD_BAD;
          end
        end
      endcase
    end
  end

  assign tick    = (tcnt == TW'(TICK_CYCLES - 1));
  assign cur_inc = (cur_q == CW'(D - 1)) ? '0 : cur_q + CW'(1);

  always_comb begin
    ent_n   = ent;
    head_n  = head;
    tcnt_n  = tick ? '0 : tcnt + TW'(1);
    speed_n = speed;
    sc_n    = sc;
    blink_n = blink;
    play_n  = play_q;
    edit_n  = edit_q;
    dir_n   = dir_q;
    cur_n   = cur_q;
    err_n   = 1'b0;
    scroll  = 1'b0;

    if (tick) begin
      if (edit_q) blink_n = ~blink;
      if (sc == speed) begin
        sc_n   = '0;
        scroll = play_q && !edit_q;
      end else begin
        sc_n = sc + 2'd1;
      end
    end

    if (scroll) begin
      if (dir_q) head_n = (head == '0) ? HW'(W - 1) : head - HW'(1);
      else       head_n = (head == HW'(W - 1)) ? '0 : head + HW'(1);
    end

    // Commands are applied after the tick logic so they override a coincident scroll.
    case (cmd)
      CMD_GO: begin
        play_n = 1'b1;
        edit_n = 1'b0;
      end
      CMD_PAUSE: begin
        play_n = 1'b0;
        edit_n = 1'b0;
      end
      CMD_MARK: begin
        if (!edit_q) begin
          edit_n  = 1'b1;
          cur_n   = '0;
          blink_n = 1'b1;
          tcnt_n  = '0;
        end else begin
          cur_n = cur_inc;
        end
      end
      CMD_REV: dir_n = ~dir_q;
      CMD_FASTER: begin
        speed_n = (speed == 2'd0) ? 2'd0 : speed - 2'd1;
        sc_n    = '0;
        head_n  = head;
      end
      CMD_SLOWER: begin
        speed_n = (speed == 2'd3) ? 2'd3 : speed + 2'd1;
        sc_n    = '0;
        head_n  = head;
      end
      CMD_CLEAR: begin
        for (int i = 0; i < W; i++) ent_n[i] = BLANK;
        head_n = '0;
      end
      CMD_CHAR: begin
        ent_n[wrap_add(head, int'(cur_q))] = char_val;
        cur_n   = cur_inc;
        blink_n = 1'b1;
      end
      CMD_BAD: err_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < W; i++) ent[i] <= 5'(i % 10);
      head   <= '0;
      tcnt   <= '0;
      speed  <= '0;
      sc     <= '0;
      blink  <= 1'b0;
      play_q <= 1'b0;
      edit_q <= 1'b0;
      dir_q  <= 1'b0;
      cur_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ent    <= ent_n;
      head   <= head_n;
      tcnt   <= tcnt_n;
      speed  <= speed_n;
      sc     <= sc_n;
      blink  <= blink_n;
      play_q <= play_n;
      edit_q <= edit_n;
      dir_q  <= dir_n;
      cur_q  <= cur_n;
      err_q  <= err_n;
    end
  end

  // The cursor cell is blanked during the "off" half of the edit blink.
  always_comb begin
    disp = '0;
    for (int k = 0; k < D; k++) begin
      disp[5*(D-1-k) +: 5] = (edit_q && !blink && (CW'(k) == cur_q)) ? BLANK
                                                                     : ent[wrap_add(head, k)];
    end
  end

  assign cursor  = cur_q;
  assign play    = play_q;
  assign edit    = edit_q;
  assign dir     = dir_q;
  assign cmd_err = err_q;

endmodule

// File: tb/tb_scroll_banner.sv
// Bench for scroll_banner: directed scenarios plus random command bytes,
// checked each cycle against an integer model of the banner's rules.
module tb_scroll_banner;

  localparam int TICK = 4;
  localparam int W    = 10;
  localparam int D    = 6;
  localparam int CW   = $clog2(D);

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic [5*D-1:0]    disp;
  logic [CW-1:0]     cursor;
  logic              play;
  logic              edit;
  logic              dir;
  logic              cmd_err;

  scroll_banner #(.TICK_CYCLES(TICK), .W(W), .D(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .disp     (disp),
    .cursor   (cursor),
    .play     (play),
    .edit     (edit),
    .dir      (dir),
    .cmd_err  (cmd_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [5*D-1:0] exp_q[$];

  // Reference model: the banner described as plain integers
  int me [W];
  int mh, mplay, medit, mdir, mspeed, msc, mblink, mcnt, mcur, merr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < W; i++) me[i] = i % 10;
    mh = 0; mplay = 0; medit = 0; mdir = 0; mspeed = 0;
    msc = 0; mblink = 0; mcnt = 0; mcur = 0; merr = 0;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    int n_h, n_play, n_edit, n_dir, n_speed, n_sc, n_blink, n_cnt, n_cur;
    bit is_tick, do_scroll;
    logic [7:0] c;
    if (r) begin
      model_reset();
      return;
    end
    n_h = mh; n_play = mplay; n_edit = medit; n_dir = mdir; n_speed = mspeed;
    n_sc = msc; n_blink = mblink; n_cur = mcur;
    is_tick = (mcnt == TICK - 1);
    n_cnt = (mcnt + 1) % TICK;
    do_scroll = 0;
    if (is_tick) begin
      if (medit != 0) n_blink = 1 - mblink;
      if (msc == mspeed) begin
        n_sc = 0;
        do_scroll = (mplay != 0) && (medit == 0);
      end else begin
        n_sc = msc + 1;
      end
    end
    if (do_scroll) n_h = (mdir != 0) ? (mh + W - 1) % W : (mh + 1) % W;
    merr = 0;
    if (v) begin
      c = d;
      if (c >= "A" && c <= "Z") c = c + 8'd32;
      case (c)
        "g": begin n_play = 1; n_edit = 0; end
        "p": begin n_play = 0; n_edit = 0; end
        "m": begin
          if (medit == 0) begin n_edit = 1; n_cur = 0; n_blink = 1; n_cnt = 0; end
          else n_cur = (mcur + 1) % D;
        end
        "r": n_dir = 1 - mdir;
        "+": begin n_speed = (mspeed > 0) ? mspeed - 1 : 0; n_sc = 0; n_h = mh; end
        "-": begin n_speed = (mspeed < 3) ? mspeed + 1 : 3; n_sc = 0; n_h = mh; end
        "c": begin
          for (int i = 0; i < W; i++) me[i] = 16;
          n_h = 0;
        end
        default: begin
          if ((c >= "0" && c <= "9") || c == " " || c == "_") begin
            if (medit != 0) begin
              me[(mh + mcur) % W] = (c == " " || c == "_") ? 16 : int'(c - "0");
              n_cur = (mcur + 1) % D;
              n_blink = 1;
            end else begin
              merr = 1;
            end
          end else begin
            merr = 1;
          end
        end
      endcase
    end
    mh = n_h; mplay = n_play; medit = n_edit; mdir = n_dir; mspeed = n_speed;
    msc = n_sc; mblink = n_blink; mcnt = n_cnt; mcur = n_cur;
  endtask

  function automatic logic [5*D-1:0] model_disp();
    logic [5*D-1:0] o;
    int ch;
    o = '0;
    for (int k = 0; k < D; k++) begin
      ch = me[(mh + k) % W];
      if (medit != 0 && mblink == 0 && k == mcur) ch = 16;
      o[5*(D-1-k) +: 5] = 5'(ch);
    end
    return o;
  endfunction

  function automatic logic [5*D-1:0] pack6(input int a, b, c, d, e, f);
    return {5'(a), 5'(b), 5'(c), 5'(d), 5'(e), 5'(f)};
  endfunction

  task automatic compare_all();
    logic [5*D-1:0] exp_d;
    if (exp_q.size() == 0) begin
      check_eq("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    exp_d = exp_q.pop_front();
    check_eq("disp",    32'(disp),    32'(exp_d));
    check_eq("cursor",  32'(cursor),  32'(mcur));
    check_eq("play",    32'(play),    32'(mplay));
    check_eq("edit",    32'(edit),    32'(medit));
    check_eq("dir",     32'(dir),     32'(mdir));
    check_eq("cmd_err", 32'(cmd_err), 32'(merr));
  endtask

  // Driver: inputs change at negedge, outputs sampled at the following negedge
  task automatic step(input logic v, input logic [7:0] d);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    model_step(v, d, rst);
    exp_q.push_back(model_disp());
    @(negedge clk);
    compare_all();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  task automatic run_to_tick();
    for (int i = 0; i < 2 * TICK && mcnt != TICK - 1; i++) step(1'b0, 8'h00);
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_disp"},   32'(disp),    32'(pack6(0, 1, 2, 3, 4, 5)));
    check_eq({tag, "_status"}, 32'({play, edit, dir, cmd_err}), 32'd0);
    check_eq({tag, "_cursor"}, 32'(cursor),  32'd0);
  endtask

  logic [7:0] pool [26] = '{"g", "G", "p", "P", "m", "M", "r", "R", "+", "-",
                            "c", "0", "1", "2", "3", "4", "5", "6", "7", "8",
                            "9", " ", "_", "x", "m", "m"};

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset(2);
    check_reset_state("reset");

    // Left scroll through the wrap point
    step(1'b1, "g");
    idle(19);
    check_eq("left5_disp", 32'(disp), 32'(pack6(5, 6, 7, 8, 9, 0)));

    // Reset held mid-scroll
    do_reset(3);
    check_reset_state("rst_mid");

    // Reverse direction, then saturate the slowest speed
    step(1'b1, "g");
    step(1'b1, "r");
    idle(2);
    check_eq("right1_disp", 32'(disp), 32'(pack6(9, 0, 1, 2, 3, 4)));
    for (int i = 0; i < 5; i++) step(1'b1, "-");
    idle(40);

    // Cursor editing and blink
    do_reset(1);
    step(1'b1, "m");
    step(1'b1, "7");
    step(1'b1, "m");
    step(1'b1, "_");
    check_eq("edit_disp",   32'(disp),   32'(pack6(7, 1, 16, 3, 4, 5)));
    check_eq("edit_cursor", 32'(cursor), 32'd3);
    check_eq("edit_mode",   32'(edit),   32'd1);
    idle(12);
    step(1'b1, "p");
    check_eq("pause_edit", 32'(edit), 32'd0);
    idle(8);

    // Rejected bytes
    do_reset(1);
    step(1'b1, "x");
    check_eq("err_x", 32'(cmd_err), 32'd1);
    step(1'b1, "5");
    check_eq("err_digit", 32'(cmd_err), 32'd1);
    idle(1);
    check_eq("err_clear", 32'(cmd_err), 32'd0);
    check_eq("err_disp",  32'(disp), 32'(pack6(0, 1, 2, 3, 4, 5)));

    // Speed change and clear landing on a scroll tick
    do_reset(1);
    step(1'b1, "g");
    run_to_tick();
    step(1'b1, "+");
    check_eq("plus_tick_disp", 32'(disp), 32'(pack6(0, 1, 2, 3, 4, 5)));
    run_to_tick();
    step(1'b1, "C");
    check_eq("clear_tick_disp", 32'(disp), 32'(pack6(16, 16, 16, 16, 16, 16)));
    check_eq("clear_tick_play", 32'(play), 32'd1);
    idle(6);

    // Random command traffic, including back-to-back bytes and resets
    do_reset(1);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(1, 3));
      end else if ($urandom_range(0, 2) == 0) begin
        if ($urandom_range(0, 9) == 0) step(1'b1, 8'($urandom_range(0, 255)));
        else step(1'b1, pool[$urandom_range(0, 25)]);
      end else begin
        step(1'b0, 8'($urandom_range(0, 255)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/scroll_banner.md
# scroll_banner

Parametrised UART-command-driven scrolling banner for the 7-segment display path. It consumes decoded bytes from the existing `uart_rx` and keeps a circular buffer of `W` 5-bit characters, presenting a `D`-character window to the 7-seg driver. Over the same single-character command set it provides play/pause, reversible scroll direction, four scroll speeds, cursor editing with blink, blank entry and buffer clear.

## Interface
- `TICK_CYCLES`, 25_000_000: base tick period in `clk` cycles (0.5 s @50 MHz); must be ≥2.
- `W`, 10: buffer length in characters; W ≥ D.
- `D`, 6: display window width in characters; D ≥ 2.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  one-cycle strobe: `rx_data` holds a received byte (from `uart_rx` `rx_done_tick`).
- `rx_data`  in  8  received byte.
- `disp`  out  5*D  window characters; position 0 (leftmost) in bits [5*D-1 -: 5], position D-1 in [4:0].
- `cursor`  out  $clog2(D)  edit cursor position.
- `play`  out  1  scrolling enabled.
- `edit`  out  1  edit mode active.
- `dir`  out  1  0 = scroll left, 1 = scroll right.
- `cmd_err`  out  1  one-cycle pulse: byte not accepted.

## Operation
- Character code: 5'h00–5'h09 = digits 0–9; 5'h10 = blank. Driver decodes blank as all segments off.
- Buffer: entries e[0..W-1]; head pointer h (0..W-1). Window position k shows e[(h+k) mod W].
- Reset state: e[i] = i mod 10; h=0, play=0, edit=0, dir=0, speed=0, cursor=0, blink=0, all counters 0, cmd_err=0. Resulting `disp` = 0,1,2,3,4,5 (D=6).
- Base tick: counter runs 0..TICK_CYCLES-1; tick asserts in the cycle where the counter equals TICK_CYCLES-1; the counter then wraps to 0.
- Scroll: a scroll counter sc runs 0..speed and advances on each tick. Scroll occurs on a tick with sc==speed, play=1 and edit=0; sc then returns to 0. Scroll period = (speed+1)·TICK_CYCLES.
- Left scroll: h ← (h+1) mod W, so content moves left. Right scroll: h ← (h−1) mod W, wrapping 0→W-1.
- Blink: while edit=1, blink toggles on every tick. When blink=0, the cursor position shows blank. When edit=0, blink is ignored.
- Commands are acted on only when rx_valid=1. Letters are case-insensitive:
  - `g`: play=1, edit=0.
  - `p`: play=0, edit=0.
  - `m`: if edit=0: edit=1, cursor=0, blink=1, base counter cleared. Else: cursor ← cursor+1, wrapping D-1→0.
  - `r`: dir toggles.
  - `+`: speed ← speed−1, saturating at 0; sc cleared.
  - `-`: speed ← speed+1, saturating at 3; sc cleared.
  - `c`: all entries ← blank, h=0. Allowed in any mode; cursor and modes are unchanged.
  - `0`–`9` in edit: e[(h+cursor) mod W] ← digit; cursor advances with wrap; blink=1.
  - space or `_` in edit: same as a digit, but writes blank.
  - Digit, space or `_` outside edit, or any other byte: cmd_err=1 for one cycle; no state change.
- Simultaneous events:
  - Scroll and state-update decisions use register values from before the edge. `g` arriving on a tick cycle does not scroll that cycle. `r` on a tick cycle: that scroll uses the old dir.
  - `c` coinciding with a scroll: the clear wins, h=0.
  - `+`/`-` coinciding with a tick: the speed change wins; no scroll that cycle, sc=0.
  - `m` entry coinciding with a tick: blink=1, counter cleared.
- Reset mid-operation restores every reset value on the next edge, regardless of pending commands or ticks.

## Timing
- All state is registered. `disp`, `cursor`, `play`, `edit` and `dir` are combinational from registers only; there is no rx-to-output combinational path.
- Command latency: byte at edge n (rx_valid high) → new state and `disp` valid after edge n, i.e. in cycle n+1.
- `cmd_err` is registered and asserts in cycle n+1 for exactly one cycle.
- Back-to-back rx_valid on consecutive cycles must be handled, each byte in order (UART never does this; the bench does).
- First scroll after reset + `g` at cycle 0: occurs at the first tick, TICK_CYCLES−1 cycles after reset release.

## Test plan
TICK_CYCLES=4, D=6, W=10 throughout.
- Reset → `disp` = 0,1,2,3,4,5; all status outputs 0. Hold rst high for 3 cycles mid-scroll → same values on the first cycle after release.
- `g` then run 20 cycles → five left scrolls, 4 cycles apart; final `disp` = 5,6,7,8,9,0 (wrap at W).
- From reset: `g`, `r` → first scroll gives 9,0,1,2,3,4. Then `-` ×5 → speed saturates at 3; next scrolls 16 cycles apart.
- `m`, `7`, `m`, `_` → edit=1; e[0]=7; cursor 1→2; e[2]=blank; cursor=3. `disp` = 7,1,blank,3,4,5. Position 3 blanks in alternate 4-cycle windows. `p` → edit=0, no blinking.
- `x`, then `5` with edit=0 → cmd_err pulses twice for one cycle each; buffer, h and modes unchanged.
- Play running: inject `c` on the cycle a scroll tick fires → `disp` all blank, h=0, play stays 1. Inject `+` on a tick → no scroll that cycle.
